quantum_scheduler: RTL and testbench
====================================

# quantum_scheduler

Parametrised preemption controller for the multitasking processor: tracks per-process time quanta over retired user-space instructions, raises a context-switch request on expiry, process exit or (optionally) I/O, and selects the next ready process round-robin. It sits beside the control unit. It consumes the retire stream (pc, opcode) and hands the OS switch routine a saved PC and the next process index via a req/ack handshake.

## Interface
- `PC_W`, 32, PC width
- `NPROC`, 4, number of process slots (2..16)
- `IDX_W`, $clog2(NPROC), process index width
- `Q_W`, 8, quantum counter width
- `DEFAULT_Q`, 5, per-slot quantum after reset
- `OS_PC_LIMIT`, 300, PCs ≤ this are OS code and never counted
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `retire` in 1: one instruction retired this cycle
- `pc` in PC_W: PC of retiring instruction
- `opcode` in 6: opcode of retiring instruction
- `io_instr` in 1: retiring instruction is in/out
- `proc_exit` in 1: current process terminates (valid with retire)
- `proc_start` in 1: mark slot `start_idx` ready
- `start_idx` in IDX_W: slot to activate
- `cfg_we` in 1: write quantum
- `cfg_idx` in IDX_W: slot to configure
- `cfg_q` in Q_W: new quantum; 0 is stored as 1
- `switch_ack` in 1: OS has consumed the switch request
- `switch_req` out 1: context switch pending
- `switch_reason` out 2: 0 quantum, 1 exit, 2 io
- `saved_pc` out PC_W: resume PC of interrupted process
- `cur_proc` out IDX_W: running slot
- `next_proc` out IDX_W: slot to dispatch
- `any_ready` out 1: at least one slot ready

## Operation
- State machine with three states: IDLE (no ready slot), RUN, SWITCH.
- Per-slot registers:
  - `ready[NPROC]`, reset 0.
  - `quantum[NPROC]`, reset DEFAULT_Q.
  - `resume_pc[NPROC]`, reset 0.
- IDLE→RUN when `proc_start` makes any slot ready. `cur_proc` takes the lowest ready index.
- In RUN, on `retire` with `pc > OS_PC_LIMIT`, checks apply in priority order:
  1. `proc_exit`: clear `ready[cur]`; go to SWITCH with reason 1. `saved_pc` is don't-care but driven as pc+1.
  2. `io_instr` (only with `QSCHED_IO_YIELD_EN`): go to SWITCH with reason 2, `saved_pc = pc+1`.
  3. `count+1 >= quantum[cur]` and another slot is ready: go to SWITCH with reason 0, `saved_pc = pc+1`, and write `resume_pc[cur] = pc+1`.
  4. `count+1 >= quantum[cur]` and cur is the only ready slot: `count = 0`, no switch.
  5. Otherwise `count = count+1`.
- Every retired user-space instruction counts as 1, jumps and branches included. Retires with `pc ≤ OS_PC_LIMIT` are ignored, and the count holds.
- Without the macro, `io_instr` clears `count` (voluntary yield credit) and no switch occurs.
- `next_proc` comes from round-robin order: the first ready slot after `cur_proc`, wrapping modulo NPROC. It is recomputed every cycle and frozen on SWITCH entry.
- SWITCH holds `switch_req = 1` and ignores `retire`. When `switch_ack` is seen:
  - `cur_proc = next_proc`, `count = 0`.
  - Go to RUN, or to IDLE if no slot is ready (exit of last process).
- `cfg_we` and `proc_start` are accepted in any state.
- A `cfg_we` in the same cycle as an expiry check takes effect from the next cycle; the check uses the old value.

## Timing
- All outputs are registered. Reset values:
  - `switch_req` 0, `switch_reason` 0, `saved_pc` 0.
  - `cur_proc` 0, `next_proc` 0, `any_ready` 0.
- Latency: the expiring/exiting retire in cycle N gives `switch_req` high in cycle N+1.
- `switch_ack` may arrive in the same cycle `switch_req` first appears in a registered view (N+1). The earliest deassertion is cycle N+2.
- The ack is level-sampled only in SWITCH. An ack outside SWITCH is ignored.
- `count` is Q_W bits. The ≥ compare guarantees no wrap for quanta up to 2^Q_W−1.
- Reset mid-SWITCH drops the request next cycle and clears all ready bits.

## Configuration
- `QSCHED_IO_YIELD_EN` defined: an I/O instruction preempts immediately with reason 2, even if cur is the only ready slot (the OS re-dispatches it).
- Macro undefined: I/O only clears the quantum count. `switch_reason` never equals 2.

## Structure
- Shared package `sched_pkg`:
  - opcode constants: jump 6'b010001, jumpR 6'b010010, beq 6'b010100, in 6'b011101, out 6'b011110.
  - `switch_reason_t` enum.
  - `sched_state_t` enum (IDLE/RUN/SWITCH).
- Sub-module `rr_next_ready`: combinational round-robin finder with NPROC and IDX_W params. Inputs `ready` vector and `cur`; outputs `next` and `found`.

## Test plan
- Start slots 0,1; default quantum 5; 5 user retires on slot 0 at pc 400..404 → `switch_req` 1 cycle after pc 404, reason 0, `saved_pc` 405, `next_proc` 1; ack → `cur_proc` 1.
- Only slot 2 ready, 12 user retires → no `switch_req`; count wraps to 0 at 5 and 10.
- Retires at pc 100..200 interleaved with 4 user retires → no switch; the 5th user retire triggers it.
- `proc_exit` on the last ready slot → reason 1; after ack, `any_ready` 0 and state IDLE.
- `cfg_we` slot 1 with q=0, then run slot 1 alongside slot 0 → switch after every single retire.
- `io_instr` at pc 500: with macro → reason 2, `saved_pc` 501; without → count cleared and no switch until 5 further retires.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and constants for the quantum scheduler: opcode encodings,
// switch reasons and the scheduler FSM state encoding.
package sched_pkg;

  localparam logic [5:0] OP_JUMP  = 6'b010001;
  localparam logic [5:0] OP_JUMPR = 6'b010010;
  localparam logic [5:0] OP_BEQ   = 6'b010100;
  localparam logic [5:0] OP_IN    = 6'b011101;
  localparam logic [5:0] OP_OUT   = 6'b011110;

  typedef enum logic [1:0] {
    REASON_QUANTUM = 2'd0,
    REASON_EXIT    = 2'd1,
    REASON_IO      = 2'd2
  } switch_reason_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } sched_state_t;

  function automatic logic is_io_op(input logic [5:0] op);
    return (op == OP_IN) || (op == OP_OUT);
  endfunction

endpackage

// File: rtl/quantum_scheduler_if.sv
// Bundle of the retire stream, slot control and OS switch handshake between
// the control unit / OS side (master) and the quantum scheduler (slave).
interface quantum_scheduler_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 2,
  parameter int Q_W   = 8
);
  logic             retire;
  logic [PC_W-1:0]  pc;
  logic [5:0]       opcode;
  logic             io_instr;
  logic             proc_exit;
  logic             proc_start;
  logic [IDX_W-1:0] start_idx;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [Q_W-1:0]   cfg_q;
  logic             switch_ack;
  logic             switch_req;
  logic [1:0]       switch_reason;
  logic [PC_W-1:0]  saved_pc;
  logic [IDX_W-1:0] cur_proc;
  logic [IDX_W-1:0] next_proc;
  logic             any_ready;

  modport master (
    output retire, pc, opcode, io_instr, proc_exit, proc_start, start_idx,
           cfg_we, cfg_idx, cfg_q, switch_ack,
    input  switch_req, switch_reason, saved_pc, cur_proc, next_proc, any_ready
  );

  modport slave (
    input  retire, pc, opcode, io_instr, proc_exit, proc_start, start_idx,
           cfg_we, cfg_idx, cfg_q, switch_ack,
    output switch_req, switch_reason, saved_pc, cur_proc, next_proc, any_ready
  );
endinterface

// File: rtl/rr_next_ready.sv
// Combinational round-robin finder: first ready slot after cur, wrapping,
// with cur itself considered last. next is 0 when nothing is ready.
module rr_next_ready #(
  parameter int NPROC = 4,
  parameter int IDX_W = $clog2(NPROC)
) (
  input  logic [NPROC-1:0] ready,
  input  logic [IDX_W-1:0] cur,
  output logic [IDX_W-1:0] next,
  output logic             found
);

  // Walk offsets from farthest to nearest so the nearest ready slot wins.
  always_comb begin
    next  = '0;
    found = 1'b0;
    for (int k = NPROC; k >= 1; k--) begin
      if (ready[(int'(cur) + k) % NPROC]) begin
        next  = IDX_W'((int'(cur) + k) % NPROC);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemption controller: counts user-space retires per quantum and requests a
// context switch on expiry, exit or (with QSCHED_IO_YIELD_EN defined) I/O.
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int NPROC       = 4,
  parameter int IDX_W       = $clog2(NPROC),
  parameter int Q_W         = 8,
  parameter int DEFAULT_Q   = 5,
  parameter int OS_PC_LIMIT = 300
) (
  input logic               clk,
  input logic               reset,
  quantum_scheduler_if.slave bus
);

  sched_state_t     state_q, state_d;
  logic [NPROC-1:0] ready_q, ready_d;
  logic [Q_W-1:0]   quantum_q [NPROC];
  logic [Q_W-1:0]   quantum_d [NPROC];
  logic [PC_W-1:0]  resume_pc_q [NPROC];
  logic [PC_W-1:0]  resume_pc_d [NPROC];
  logic [Q_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] next_q, next_d;
  logic             switch_req_q, switch_req_d;
  switch_reason_t   reason_q, reason_d;
  logic [PC_W-1:0]  saved_pc_q, saved_pc_d;
  logic             any_ready_q, any_ready_d;

  logic             run_retire, is_io, expire, others_ready;
  logic             ev_exit, ev_io, ev_quantum, io_clear, go_switch;
  logic [Q_W:0]     cnt_inc;
  logic [PC_W-1:0]  pc_inc;
  logic [Q_W-1:0]   cfg_q_eff;
  logic [IDX_W-1:0] low_idx, rr_idx;
  logic             low_found, rr_found;

  assign run_retire   = (state_q == ST_RUN) && bus.retire && (bus.pc > PC_W'(OS_PC_LIMIT));
  assign is_io        = bus.io_instr | is_io_op(bus.opcode);
  assign pc_inc       = bus.pc + PC_W'(1);
  assign cnt_inc      = {1'b0, count_q} + (Q_W+1)'(1);
  assign expire       = cnt_inc >= {1'b0, quantum_q[cur_q]};
  assign others_ready = |(ready_q & ~(NPROC'(1) << cur_q));
  assign cfg_q_eff    = (bus.cfg_q == '0) ? Q_W'(1) : bus.cfg_q;

  assign ev_exit    = run_retire && bus.proc_exit;
`ifdef QSCHED_IO_YIELD_EN
  assign ev_io      = run_retire && !bus.proc_exit && is_io;
  assign io_clear   = 1'b0;
`else
  assign ev_io      = 1'b0;
  assign io_clear   = run_retire && !bus.proc_exit && is_io;
`endif
  assign ev_quantum = run_retire && !bus.proc_exit && !is_io && expire && others_ready;
  assign go_switch  = ev_exit || ev_io || ev_quantum;

  // Lowest ready index is the round-robin successor of the top slot.
  rr_next_ready #(.NPROC(NPROC), .IDX_W(IDX_W)) u_low (
    .ready(ready_d), .cur(IDX_W'(NPROC-1)), .next(low_idx), .found(low_found)
  );

  rr_next_ready #(.NPROC(NPROC), .IDX_W(IDX_W)) u_rr (
    .ready(ready_d), .cur(cur_d), .next(rr_idx), .found(rr_found)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NPROC; gi++) begin : g_slot
      assign quantum_d[gi]   = (bus.cfg_we && bus.cfg_idx == IDX_W'(gi)) ? cfg_q_eff
                                                                        : quantum_q[gi];
      assign resume_pc_d[gi] = (ev_quantum && cur_q == IDX_W'(gi)) ? pc_inc
                                                                   : resume_pc_q[gi];
    end
  endgenerate

  always_comb begin
    ready_d = ready_q;
    if (ev_exit)        ready_d[cur_q]         = 1'b0;
    if (bus.proc_start) ready_d[bus.start_idx] = 1'b1;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|ready_d)  state_d = ST_RUN;
      ST_RUN:    if (go_switch) state_d = ST_SWITCH;
      ST_SWITCH: if (bus.switch_ack) state_d = (|ready_d) ? ST_RUN : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_d   = cur_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (|ready_d) begin
          cur_d   = low_idx;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (run_retire) begin
          if (go_switch || io_clear || expire) count_d = '0;
          else                                 count_d = cnt_inc[Q_W-1:0];
        end
      end
      ST_SWITCH: begin
        // A frozen target that is no longer ready falls back to the lowest one.
        if (bus.switch_ack) begin
          cur_d   = (ready_d[next_q] || !low_found) ? next_q : low_idx;
          count_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    next_d = next_q;
    if (!(state_q == ST_SWITCH && !bus.switch_ack))
      next_d = rr_found ? rr_idx : '0;
  end

  // FSM outputs
  always_comb begin
    switch_req_d = (state_d == ST_SWITCH);
    reason_d     = reason_q;
    saved_pc_d   = saved_pc_q;
    any_ready_d  = |ready_d;
    if (state_q == ST_RUN && go_switch) begin
      saved_pc_d = pc_inc;
      reason_d   = ev_exit ? REASON_EXIT : (ev_io ? REASON_IO : REASON_QUANTUM);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q      <= '0;
      count_q      <= '0;
      cur_q        <= '0;
      next_q       <= '0;
      switch_req_q <= 1'b0;
      reason_q     <= REASON_QUANTUM;
      saved_pc_q   <= '0;
      any_ready_q  <= 1'b0;
      for (int i = 0; i < NPROC; i++) begin
        quantum_q[i]   <= Q_W'(DEFAULT_Q);
        resume_pc_q[i] <= '0;
      end
    end else begin
      ready_q      <= ready_d;
      count_q      <= count_d;
      cur_q        <= cur_d;
      next_q       <= next_d;
      switch_req_q <= switch_req_d;
      reason_q     <= reason_d;
      saved_pc_q   <= saved_pc_d;
      any_ready_q  <= any_ready_d;
      for (int i = 0; i < NPROC; i++) begin
        quantum_q[i]   <= quantum_d[i];
        resume_pc_q[i] <= resume_pc_d[i];
      end
    end
  end

  assign bus.switch_req    = switch_req_q;
  assign bus.switch_reason = reason_q;
  assign bus.saved_pc      = saved_pc_q;
  assign bus.cur_proc      = cur_q;
  assign bus.next_proc     = next_q;
  assign bus.any_ready     = any_ready_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Self-checking bench for quantum_scheduler: expected switch records are queued
// when the triggering retire is driven and popped when switch_req appears.
module tb_quantum_scheduler;
  import sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quantum_scheduler_if #(.PC_W(32), .IDX_W(2), .Q_W(8)) bus();

  quantum_scheduler #(
    .PC_W(32), .NPROC(4), .IDX_W(2), .Q_W(8), .DEFAULT_Q(5), .OS_PC_LIMIT(300)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [1:0]  reason;
    logic [31:0] spc;
    logic [1:0]  nxt;
    logic        chk_nxt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.retire = 0; bus.pc = '0; bus.opcode = '0; bus.io_instr = 0; bus.proc_exit = 0;
    bus.proc_start = 0; bus.start_idx = '0; bus.cfg_we = 0; bus.cfg_idx = '0;
    bus.cfg_q = '0; bus.switch_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic start(input logic [1:0] idx);
    bus.proc_start = 1'b1; bus.start_idx = idx;
    step();
    bus.proc_start = 1'b0;
    $display("start slot=%0d -> cur=%0d next=%0d any_ready=%0b",
             idx, bus.cur_proc, bus.next_proc, bus.any_ready);
  endtask

  task automatic retire_one(input logic [31:0] p, input logic io, input logic ex,
                            input logic [5:0] op);
    bus.retire = 1'b1; bus.pc = p; bus.io_instr = io; bus.proc_exit = ex; bus.opcode = op;
    step();
    bus.retire = 1'b0; bus.io_instr = 1'b0; bus.proc_exit = 1'b0; bus.opcode = '0;
    $display("retire pc=%0d io=%0b exit=%0b -> req=%0b reason=%0d saved_pc=%0d next=%0d",
             p, io, ex, bus.switch_req, bus.switch_reason, bus.saved_pc, bus.next_proc);
  endtask

  task automatic ack();
    bus.switch_ack = 1'b1;
    step();
    bus.switch_ack = 1'b0;
    $display("ack -> req=%0b cur=%0d any_ready=%0b", bus.switch_req, bus.cur_proc, bus.any_ready);
  endtask

  function automatic logic [5:0] op_of(input int i);
    logic [5:0] ops [4];
    ops[0] = 6'b000000; ops[1] = OP_JUMP; ops[2] = OP_BEQ; ops[3] = OP_JUMPR;
    return ops[i % 4];
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0b exp=0", bus.switch_req); end
    n_cmp++; if (bus.switch_reason !== 2'd0) begin n_bad++; $display("FAIL reset_reason got=%0d exp=0", bus.switch_reason); end
    n_cmp++; if (bus.saved_pc !== 32'd0) begin n_bad++; $display("FAIL reset_saved_pc got=%0d exp=0", bus.saved_pc); end
    n_cmp++; if (bus.cur_proc !== 2'd0) begin n_bad++; $display("FAIL reset_cur got=%0d exp=0", bus.cur_proc); end
    n_cmp++; if (bus.next_proc !== 2'd0) begin n_bad++; $display("FAIL reset_next got=%0d exp=0", bus.next_proc); end
    n_cmp++; if (bus.any_ready !== 1'b0) begin n_bad++; $display("FAIL reset_any_ready got=%0b exp=0", bus.any_ready); end
  endtask

  task automatic test_quantum_expiry();
    do_reset();
    start(2'd0); start(2'd1);
    n_cmp++; if (bus.cur_proc !== 2'd0) begin n_bad++; $display("FAIL qexp_cur0 got=%0d exp=0", bus.cur_proc); end
    n_cmp++; if (bus.next_proc !== 2'd1) begin n_bad++; $display("FAIL qexp_next_run got=%0d exp=1", bus.next_proc); end
    n_cmp++; if (bus.any_ready !== 1'b1) begin n_bad++; $display("FAIL qexp_any_ready got=%0b exp=1", bus.any_ready); end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) sb.push_back('{reason: 2'd0, spc: 32'd405, nxt: 2'd1, chk_nxt: 1'b1});
      retire_one(32'd400 + 32'(i), 1'b0, 1'b0, op_of(i));
      n_cmp++; if (bus.switch_req !== (i == 4)) begin n_bad++; $display("FAIL qexp_req[%0d] got=%0b exp=%0b", i, bus.switch_req, (i == 4)); end
    end
    if (bus.switch_req === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; if (bus.switch_reason !== e.reason) begin n_bad++; $display("FAIL qexp_reason got=%0d exp=%0d", bus.switch_reason, e.reason); end
      n_cmp++; if (bus.saved_pc !== e.spc) begin n_bad++; $display("FAIL qexp_saved_pc got=%0d exp=%0d", bus.saved_pc, e.spc); end
      n_cmp++; if (e.chk_nxt && bus.next_proc !== e.nxt) begin n_bad++; $display("FAIL qexp_next got=%0d exp=%0d", bus.next_proc, e.nxt); end
    end
    ack();
    n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL qexp_req_drop got=%0b exp=0", bus.switch_req); end
    n_cmp++; if (bus.cur_proc !== 2'd1) begin n_bad++; $display("FAIL qexp_cur_after got=%0d exp=1", bus.cur_proc); end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL qexp_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_single_slot();
    do_reset();
    start(2'd2);
    n_cmp++; if (bus.cur_proc !== 2'd2) begin n_bad++; $display("FAIL single_cur got=%0d exp=2", bus.cur_proc); end
    for (int i = 0; i < 12; i++) begin
      retire_one(32'd600 + 32'(i), 1'b0, 1'b0, op_of(i));
      n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL single_req[%0d] got=%0b exp=0", i, bus.switch_req); end
    end
    // count is 2 after 12 retires, so three more expire once slot 0 joins
    start(2'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) sb.push_back('{reason: 2'd0, spc: 32'd703, nxt: 2'd0, chk_nxt: 1'b1});
      retire_one(32'd700 + 32'(i), 1'b0, 1'b0, 6'd0);
      n_cmp++; if (bus.switch_req !== (i == 2)) begin n_bad++; $display("FAIL single_wrap_req[%0d] got=%0b exp=%0b", i, bus.switch_req, (i == 2)); end
    end
    if (bus.switch_req === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; if (bus.switch_reason !== e.reason) begin n_bad++; $display("FAIL single_reason got=%0d exp=%0d", bus.switch_reason, e.reason); end
      n_cmp++; if (bus.saved_pc !== e.spc) begin n_bad++; $display("FAIL single_saved_pc got=%0d exp=%0d", bus.saved_pc, e.spc); end
      n_cmp++; if (e.chk_nxt && bus.next_proc !== e.nxt) begin n_bad++; $display("FAIL single_next got=%0d exp=%0d", bus.next_proc, e.nxt); end
    end
    ack();
    n_cmp++; if (bus.cur_proc !== 2'd0) begin n_bad++; $display("FAIL single_cur_after got=%0d exp=0", bus.cur_proc); end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL single_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_os_filter();
    logic [31:0] os_pc [5];
    os_pc[0] = 32'd100; os_pc[1] = 32'd150; os_pc[2] = 32'd200; os_pc[3] = 32'd250; os_pc[4] = 32'd300;
    do_reset();
    start(2'd0); start(2'd1);
    for (int i = 0; i < 5; i++) begin
      retire_one(os_pc[i], 1'b0, (i == 4), 6'd0);
      n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL os_req[%0d] got=%0b exp=0", i, bus.switch_req); end
      if (i == 4) sb.push_back('{reason: 2'd0, spc: 32'd905, nxt: 2'd1, chk_nxt: 1'b1});
      retire_one(32'd900 + 32'(i), 1'b0, 1'b0, op_of(i));
      n_cmp++; if (bus.switch_req !== (i == 4)) begin n_bad++; $display("FAIL os_user_req[%0d] got=%0b exp=%0b", i, bus.switch_req, (i == 4)); end
    end
    if (bus.switch_req === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; if (bus.switch_reason !== e.reason) begin n_bad++; $display("FAIL os_reason got=%0d exp=%0d", bus.switch_reason, e.reason); end
      n_cmp++; if (bus.saved_pc !== e.spc) begin n_bad++; $display("FAIL os_saved_pc got=%0d exp=%0d", bus.saved_pc, e.spc); end
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL os_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_exit_last();
    do_reset();
    start(2'd3);
    ack();
    n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL exit_stray_ack_req got=%0b exp=0", bus.switch_req); end
    n_cmp++; if (bus.cur_proc !== 2'd3) begin n_bad++; $display("FAIL exit_stray_ack_cur got=%0d exp=3", bus.cur_proc); end
    sb.push_back('{reason: 2'd1, spc: 32'd801, nxt: 2'd0, chk_nxt: 1'b0});
    retire_one(32'd800, 1'b0, 1'b1, 6'd0);
    n_cmp++; if (bus.switch_req !== 1'b1) begin n_bad++; $display("FAIL exit_req got=%0b exp=1", bus.switch_req); end
    if (bus.switch_req === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; if (bus.switch_reason !== e.reason) begin n_bad++; $display("FAIL exit_reason got=%0d exp=%0d", bus.switch_reason, e.reason); end
      n_cmp++; if (bus.saved_pc !== e.spc) begin n_bad++; $display("FAIL exit_saved_pc got=%0d exp=%0d", bus.saved_pc, e.spc); end
    end
    ack();
    n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL exit_req_drop got=%0b exp=0", bus.switch_req); end
    n_cmp++; if (bus.any_ready !== 1'b0) begin n_bad++; $display("FAIL exit_any_ready got=%0b exp=0", bus.any_ready); end
    retire_one(32'd900, 1'b0, 1'b0, 6'd0);
    n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL exit_idle_req got=%0b exp=0", bus.switch_req); end
    start(2'd1);
    n_cmp++; if (bus.cur_proc !== 2'd1) begin n_bad++; $display("FAIL exit_restart_cur got=%0d exp=1", bus.cur_proc); end
    n_cmp++; if (bus.any_ready !== 1'b1) begin n_bad++; $display("FAIL exit_restart_ready got=%0b exp=1", bus.any_ready); end
  endtask

  task automatic test_cfg_zero();
    do_reset();
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'd1; bus.cfg_q = 8'd0;
    step();
    bus.cfg_we = 1'b0;
    start(2'd0); start(2'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        // same-cycle write must not affect this expiry check
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_q = 8'd9;
        sb.push_back('{reason: 2'd0, spc: 32'd405, nxt: 2'd1, chk_nxt: 1'b1});
      end
      retire_one(32'd400 + 32'(i), 1'b0, 1'b0, 6'd0);
      bus.cfg_we = 1'b0;
      n_cmp++; if (bus.switch_req !== (i == 4)) begin n_bad++; $display("FAIL cfg_s0_req[%0d] got=%0b exp=%0b", i, bus.switch_req, (i == 4)); end
    end
    if (bus.switch_req === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; if (bus.saved_pc !== e.spc) begin n_bad++; $display("FAIL cfg_s0_saved_pc got=%0d exp=%0d", bus.saved_pc, e.spc); end
      n_cmp++; if (bus.next_proc !== e.nxt) begin n_bad++; $display("FAIL cfg_s0_next got=%0d exp=%0d", bus.next_proc, e.nxt); end
    end
    ack();
    sb.push_back('{reason: 2'd0, spc: 32'd411, nxt: 2'd0, chk_nxt: 1'b1});
    retire_one(32'd410, 1'b0, 1'b0, OP_JUMP);
    n_cmp++; if (bus.switch_req !== 1'b1) begin n_bad++; $display("FAIL cfg_s1_req got=%0b exp=1", bus.switch_req); end
    if (bus.switch_req === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; if (bus.saved_pc !== e.spc) begin n_bad++; $display("FAIL cfg_s1_saved_pc got=%0d exp=%0d", bus.saved_pc, e.spc); end
      n_cmp++; if (bus.next_proc !== e.nxt) begin n_bad++; $display("FAIL cfg_s1_next got=%0d exp=%0d", bus.next_proc, e.nxt); end
    end
    ack();
    n_cmp++; if (bus.cur_proc !== 2'd0) begin n_bad++; $display("FAIL cfg_cur_back got=%0d exp=0", bus.cur_proc); end
    for (int i = 0; i < 9; i++) begin
      retire_one(32'd500 + 32'(i), 1'b0, 1'b0, op_of(i));
      n_cmp++; if (bus.switch_req !== (i == 8)) begin n_bad++; $display("FAIL cfg_q9_req[%0d] got=%0b exp=%0b", i, bus.switch_req, (i == 8)); end
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL cfg_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_io();
    do_reset();
    start(2'd0); start(2'd1);
    retire_one(32'd400, 1'b0, 1'b0, 6'd0);
    retire_one(32'd401, 1'b0, 1'b0, 6'd0);
`ifdef QSCHED_IO_YIELD_EN
    sb.push_back('{reason: 2'd2, spc: 32'd501, nxt: 2'd1, chk_nxt: 1'b1});
    retire_one(32'd500, 1'b1, 1'b0, OP_IN);
    n_cmp++; if (bus.switch_req !== 1'b1) begin n_bad++; $display("FAIL io_req got=%0b exp=1", bus.switch_req); end
`else
    retire_one(32'd500, 1'b1, 1'b0, OP_IN);
    n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL io_req got=%0b exp=0", bus.switch_req); end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) sb.push_back('{reason: 2'd0, spc: 32'd507, nxt: 2'd1, chk_nxt: 1'b1});
      retire_one(32'd502 + 32'(i), 1'b0, 1'b0, 6'd0);
      n_cmp++; if (bus.switch_req !== (i == 4)) begin n_bad++; $display("FAIL io_after_req[%0d] got=%0b exp=%0b", i, bus.switch_req, (i == 4)); end
    end
`endif
    if (bus.switch_req === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; if (bus.switch_reason !== e.reason) begin n_bad++; $display("FAIL io_reason got=%0d exp=%0d", bus.switch_reason, e.reason); end
      n_cmp++; if (bus.saved_pc !== e.spc) begin n_bad++; $display("FAIL io_saved_pc got=%0d exp=%0d", bus.saved_pc, e.spc); end
      n_cmp++; if (bus.next_proc !== e.nxt) begin n_bad++; $display("FAIL io_next got=%0d exp=%0d", bus.next_proc, e.nxt); end
    end
    ack();
    n_cmp++; if (bus.cur_proc !== 2'd1) begin n_bad++; $display("FAIL io_cur_after got=%0d exp=1", bus.cur_proc); end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL io_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_mid_switch();
    do_reset();
    start(2'd0); start(2'd1);
    for (int i = 0; i < 5; i++) retire_one(32'd400 + 32'(i), 1'b0, 1'b0, 6'd0);
    n_cmp++; if (bus.switch_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_req_before got=%0b exp=1", bus.switch_req); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("reset mid-switch -> req=%0b any_ready=%0b", bus.switch_req, bus.any_ready);
    n_cmp++; if (bus.switch_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_req got=%0b exp=0", bus.switch_req); end
    n_cmp++; if (bus.any_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready got=%0b exp=0", bus.any_ready); end
    n_cmp++; if (bus.saved_pc !== 32'd0) begin n_bad++; $display("FAIL rst_mid_saved_pc got=%0d exp=0", bus.saved_pc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_quantum_expiry();
    test_single_slot();
    test_os_filter();
    test_exit_last();
    test_cfg_zero();
    test_io();
    test_reset_mid_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
